// File: rtl/usb_ep_in_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_ep_in_arbiter_if                                                       |
// | Per-end-point AXI-S sources and the single encoder-bound AXI-S sink.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface usb_ep_in_arbiter_if #(
   parameter int NUM_EPS = 2
);
   logic [NUM_EPS-1:0]   s_tvalid;
   logic [NUM_EPS-1:0]   s_tready;
   logic [NUM_EPS-1:0]   s_tlast;
   logic [NUM_EPS-1:0]   s_tkeep;
   logic [8*NUM_EPS-1:0] s_tdata;
   logic                 m_tvalid;
   logic                 m_tready;
   logic                 m_tlast;
   logic                 m_tkeep;
   logic [7:0]           m_tdata;

   // master: the end-point sources plus the encoder sink (environment side)
   modport master (
      output s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
      input  s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata
   );

   // slave: the arbiter itself
   modport slave (
      input  s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
      output s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata
   );
endinterface
`default_nettype wire

// File: rtl/usb_ep_in_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_ep_in_arbiter                                                          |
// | Grants the Bulk-In transmit path to the token-addressed IN end-point.      |
// | Optional packet statistics: define USB_ARB_STATS_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module usb_ep_in_arbiter #(
   parameter int NUM_EPS = 2,
   parameter int EP_BASE = 1,
   parameter int TIMEOUT = 256
) (
   input  wire                clock,
   input  wire                reset,
   input  wire                tok_recv_i,
   input  wire  [3:0]         tok_endp_i,
   input  wire                ack_recv_i,
   input  wire                timedout_i,
   output logic               nak_o,
   output logic               busy_o,
   output logic               err_o,
   input  wire  [NUM_EPS-1:0] ep_ready_i,
   output logic [NUM_EPS-1:0] ep_sel_o,
   output logic [NUM_EPS-1:0] ep_ack_o,
   output logic [NUM_EPS-1:0] ep_tout_o,
   usb_ep_in_arbiter_if.slave axis,
   output logic [15:0]        stat_ack_o,
   output logic [15:0]        stat_nak_o
);

   localparam int            TICK_W      = $clog2(TIMEOUT);
   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      SEND = 4'b0010,
      WAIT = 4'b0100,
      ABRT = 4'b1000
   } state_t;

   state_t              state_q;
   logic [1:0]          gnt_q;
   logic [TICK_W-1:0]   tick_q;

   logic [3:0]          ready_pad;
   logic [3:0]          vld_pad;
   logic [3:0]          last_pad;
   logic [3:0]          keep_pad;
   logic [7:0]          data_pad [4];
   logic [3:0]          idx;
   logic                idx_ok;
   logic                beat;
   logic [NUM_EPS-1:0]  gnt_oh;

   // Widen every per-end-point input to four lanes so a 2-bit grant index is always in range.
   generate
      for (genvar k = 0; k < 4; k++) begin : g_pad
         if (k < NUM_EPS) begin : g_live
            assign ready_pad[k] = ep_ready_i[k];
            assign vld_pad[k]   = axis.s_tvalid[k];
            assign last_pad[k]  = axis.s_tlast[k];
            assign keep_pad[k]  = axis.s_tkeep[k];
            assign data_pad[k]  = axis.s_tdata[8*k +: 8];
         end else begin : g_absent
            assign ready_pad[k] = 1'b0;
            assign vld_pad[k]   = 1'b0;
            assign last_pad[k]  = 1'b0;
            assign keep_pad[k]  = 1'b0;
            assign data_pad[k]  = 8'h00;
         end
      end
   endgenerate

   // Addresses below EP_BASE wrap to a large index and fail the range test.
   assign idx    = tok_endp_i - 4'(EP_BASE);
   assign idx_ok = (idx < 4'(NUM_EPS)) && ready_pad[idx[1:0]];
   assign gnt_oh = NUM_EPS'(1) << gnt_q;
   assign beat   = (state_q == SEND) && vld_pad[gnt_q] && axis.m_tready;

   assign busy_o    = (state_q != IDLE);
   assign ep_sel_o  = busy_o ? gnt_oh : '0;
   assign ep_ack_o  = ((state_q == WAIT) && ack_recv_i) ? gnt_oh : '0;
   assign ep_tout_o = ((state_q == WAIT) && timedout_i && !ack_recv_i) ? gnt_oh : '0;

   assign axis.s_tready = ((state_q == SEND) && axis.m_tready) ? gnt_oh : '0;
   assign axis.m_tvalid = (state_q == SEND) ? vld_pad[gnt_q]  : (state_q == ABRT);
   assign axis.m_tlast  = (state_q == SEND) ? last_pad[gnt_q] : (state_q == ABRT);
   assign axis.m_tkeep  = (state_q == SEND) ? keep_pad[gnt_q] : 1'b0;
   assign axis.m_tdata  = (state_q == SEND) ? data_pad[gnt_q] : 8'h00;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 2'd0;
         tick_q  <= TICK_RELOAD;
         nak_o   <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         nak_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tok_recv_i) begin
                  if (idx_ok) begin
                     gnt_q   <= idx[1:0];
                     tick_q  <= TICK_RELOAD;
                     state_q <= SEND;
                  end else begin
                     nak_o <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (beat) begin
                  tick_q <= TICK_RELOAD;
                  if (last_pad[gnt_q]) state_q <= WAIT;
               end else if (tick_q == '0) begin
                  state_q <= ABRT;
                  err_o   <= 1'b1;
               end else begin
                  tick_q <= tick_q - 1'b1;
               end
            end
            WAIT: begin
               if (ack_recv_i || timedout_i) state_q <= IDLE;
            end
            ABRT: begin
               if (axis.m_tready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef USB_ARB_STATS_EN
   logic [15:0] ack_cnt_q;
   logic [15:0] nak_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         ack_cnt_q <= 16'h0000;
         nak_cnt_q <= 16'h0000;
      end else begin
         if ((state_q == WAIT) && ack_recv_i) ack_cnt_q <= ack_cnt_q + 16'd1;
         if (nak_o)                           nak_cnt_q <= nak_cnt_q + 16'd1;
      end
   end

   assign stat_ack_o = ack_cnt_q;
   assign stat_nak_o = nak_cnt_q;
`else
   assign stat_ack_o = 16'h0000;
   assign stat_nak_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_in_arbiter.sv
`default_nettype none
// Self-checking bench for usb_ep_in_arbiter (NUM_EPS=2, EP_BASE=1, TIMEOUT=256).
module tb_usb_ep_in_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tok_recv = 1'b0;
   logic [3:0]  tok_endp = 4'd0;
   logic        ack = 1'b0;
   logic        tout = 1'b0;
   logic [1:0]  ep_ready = 2'b00;
   logic        nak, busy, err;
   logic [1:0]  ep_sel, ep_ack, ep_tout;
   logic [15:0] stat_ack, stat_nak;

   int total = 0;
   int bad   = 0;

`ifdef USB_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       keep;
   } beat_t;
   beat_t sb [$];

   usb_ep_in_arbiter_if #(.NUM_EPS(2)) axis ();

   usb_ep_in_arbiter #(.NUM_EPS(2), .EP_BASE(1), .TIMEOUT(256)) dut (
      .clock      (clk),
      .reset      (rst),
      .tok_recv_i (tok_recv),
      .tok_endp_i (tok_endp),
      .ack_recv_i (ack),
      .timedout_i (tout),
      .nak_o      (nak),
      .busy_o     (busy),
      .err_o      (err),
      .ep_ready_i (ep_ready),
      .ep_sel_o   (ep_sel),
      .ep_ack_o   (ep_ack),
      .ep_tout_o  (ep_tout),
      .axis       (axis),
      .stat_ack_o (stat_ack),
      .stat_nak_o (stat_nak)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every accepted encoder beat must match the oldest expectation.
   always @(negedge clk) begin
      #3;
      if (!rst && axis.m_tvalid === 1'b1 && axis.m_tready === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_beat: got data=%0h last=%0b keep=%0b want no beat",
                     axis.m_tdata, axis.m_tlast, axis.m_tkeep);
         end else begin
            beat_t e;
            e = sb.pop_front();
            if (axis.m_tlast !== e.last || axis.m_tkeep !== e.keep ||
                (e.keep && axis.m_tdata !== e.data)) begin
               bad++;
               $display("FAIL sb_beat: got data=%0h last=%0b keep=%0b want data=%0h last=%0b keep=%0b",
                        axis.m_tdata, axis.m_tlast, axis.m_tkeep, e.data, e.last, e.keep);
            end
         end
      end
   end

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic idle_sources();
      axis.s_tvalid = 2'b00;
      axis.s_tlast  = 2'b00;
      axis.s_tkeep  = 2'b00;
      axis.s_tdata  = 16'h0000;
   endtask

   // Drive one byte from source 1 and record it as expected at the encoder.
   task automatic drive_ep1(input logic [7:0] d, input logic last);
      beat_t b;
      axis.s_tvalid = 2'b11;
      axis.s_tlast  = {last, 1'b1};
      axis.s_tkeep  = 2'b11;
      axis.s_tdata  = {d, 8'h55};
      b.data = d; b.last = last; b.keep = 1'b1;
      if (axis.m_tready) sb.push_back(b);
   endtask

   task automatic drive_ep0(input logic [7:0] d, input logic last);
      beat_t b;
      axis.s_tvalid = 2'b01;
      axis.s_tlast  = {1'b0, last};
      axis.s_tkeep  = 2'b01;
      axis.s_tdata  = {8'hEE, d};
      b.data = d; b.last = last; b.keep = 1'b1;
      if (axis.m_tready) sb.push_back(b);
   endtask

   task automatic token(input logic [3:0] e);
      next_cycle();
      tok_recv = 1'b1;
      tok_endp = e;
      next_cycle();
      tok_recv = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_sources();
      axis.m_tready = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      total++;
      if ({nak, busy, err, ep_sel, axis.s_tready, axis.m_tvalid, axis.m_tlast, axis.m_tkeep} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {nak, busy, err, ep_sel, axis.s_tready,
                  axis.m_tvalid, axis.m_tlast, axis.m_tkeep});
      end
      total++;
      if (stat_ack !== 16'd0 || stat_nak !== 16'd0) begin
         bad++;
         $display("FAIL reset_stats: got ack=%0d nak=%0d want 0 0", stat_ack, stat_nak);
      end
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_send_ack();
      ep_ready = 2'b10;
      token(4'd2);
      #1;
      total++;
      if (busy !== 1'b1 || ep_sel !== 2'b10) begin
         bad++;
         $display("FAIL grant_ep1: got busy=%b sel=%b want 1 10", busy, ep_sel);
      end
      for (int i = 0; i < 4; i++) begin
         drive_ep1(8'hA0 + 8'(i), i == 3);
         #1;
         total++;
         if (axis.s_tready !== 2'b10 || axis.m_tdata !== 8'hA0 + 8'(i)) begin
            bad++;
            $display("FAIL pass_through: got tready=%b data=%0h want 10 %0h",
                     axis.s_tready, axis.m_tdata, 8'hA0 + 8'(i));
         end
         next_cycle();
      end
      idle_sources();
      #1;
      total++;
      if (busy !== 1'b1 || axis.s_tready !== 2'b00 || ep_ack !== 2'b00) begin
         bad++;
         $display("FAIL wait_state: got busy=%b tready=%b ack=%b want 1 00 00", busy, axis.s_tready, ep_ack);
      end
      next_cycle();
      ack = 1'b1;
      #1;
      total++;
      if (ep_ack !== 2'b10 || ep_tout !== 2'b00) begin
         bad++;
         $display("FAIL ack_route: got ack=%b tout=%b want 10 00", ep_ack, ep_tout);
      end
      next_cycle();
      ack = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || ep_ack !== 2'b00 || stat_ack !== 16'(STATS)) begin
         bad++;
         $display("FAIL after_ack: got busy=%b ack=%b stat=%0d want 0 00 %0d", busy, ep_ack, stat_ack, STATS);
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain_1: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_nak();
      logic [3:0] eps [3];
      eps[0] = 4'd1; eps[1] = 4'd0; eps[2] = 4'd3;
      ep_ready = 2'b10;
      for (int i = 0; i < 3; i++) begin
         token(eps[i]);
         #1;
         total++;
         if (nak !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL nak_pulse ep=%0d: got nak=%b busy=%b want 1 0", eps[i], nak, busy);
         end
         next_cycle();
         #1;
         total++;
         if (nak !== 1'b0) begin
            bad++;
            $display("FAIL nak_width ep=%0d: got %b want 0", eps[i], nak);
         end
      end
      total++;
      if (stat_nak !== 16'(3 * STATS)) begin
         bad++;
         $display("FAIL stat_nak: got %0d want %0d", stat_nak, 3 * STATS);
      end
   endtask

   task automatic test_watchdog_abort();
      beat_t b;
      ep_ready = 2'b11;
      token(4'd2);
      drive_ep1(8'hB0, 1'b0);
      next_cycle();
      drive_ep1(8'hB1, 1'b0);
      next_cycle();
      idle_sources();
      axis.m_tready = 1'b0;
      for (int i = 0; i < 255; i++) next_cycle();
      #1;
      total++;
      if (err !== 1'b0 || busy !== 1'b1 || axis.m_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL wd_255: got err=%b busy=%b valid=%b want 0 1 0", err, busy, axis.m_tvalid);
      end
      next_cycle();
      #1;
      total++;
      if (err !== 1'b1 || axis.m_tvalid !== 1'b1 || axis.m_tlast !== 1'b1 || axis.m_tkeep !== 1'b0 ||
          axis.s_tready !== 2'b00 || ep_sel !== 2'b10) begin
         bad++;
         $display("FAIL abort_beat: got err=%b v=%b l=%b k=%b rdy=%b sel=%b want 1 1 1 0 00 10",
                  err, axis.m_tvalid, axis.m_tlast, axis.m_tkeep, axis.s_tready, ep_sel);
      end
      next_cycle();
      b.data = 8'h00; b.last = 1'b1; b.keep = 1'b0;
      sb.push_back(b);
      axis.m_tready = 1'b1;
      next_cycle();
      #1;
      total++;
      if (busy !== 1'b0 || err !== 1'b1 || ep_ack !== 2'b00 || ep_tout !== 2'b00) begin
         bad++;
         $display("FAIL abort_exit: got busy=%b err=%b ack=%b tout=%b want 0 1 00 00", busy, err, ep_ack, ep_tout);
      end
      next_cycle();
      next_cycle();
      #1;
      total++;
      if (err !== 1'b1 || sb.size() != 0) begin
         bad++;
         $display("FAIL err_sticky: got err=%b pending=%0d want 1 0", err, sb.size());
      end
   endtask

   task automatic test_ack_tout();
      ep_ready = 2'b01;
      token(4'd1);
      drive_ep0(8'hD0, 1'b1);
      next_cycle();
      idle_sources();
      ack = 1'b1;
      tout = 1'b1;
      #1;
      total++;
      if (ep_ack !== 2'b01 || ep_tout !== 2'b00) begin
         bad++;
         $display("FAIL ack_wins: got ack=%b tout=%b want 01 00", ep_ack, ep_tout);
      end
      next_cycle();
      ack = 1'b0;
      tout = 1'b0;
      token(4'd1);
      drive_ep0(8'hD1, 1'b1);
      next_cycle();
      idle_sources();
      tout = 1'b1;
      #1;
      total++;
      if (ep_tout !== 2'b01 || ep_ack !== 2'b00) begin
         bad++;
         $display("FAIL tout_route: got tout=%b ack=%b want 01 00", ep_tout, ep_ack);
      end
      next_cycle();
      tout = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL tout_exit: got busy=%b want 0", busy);
      end
      token(4'd1);
      #1;
      total++;
      if (ep_sel !== 2'b01 || busy !== 1'b1) begin
         bad++;
         $display("FAIL regrant: got sel=%b busy=%b want 01 1", ep_sel, busy);
      end
   endtask

   task automatic test_reset_mid();
      drive_ep0(8'hD2, 1'b0);
      next_cycle();
      axis.s_tvalid = 2'b01;
      axis.s_tdata  = 16'h00D3;
      rst = 1'b1;
      next_cycle();
      #1;
      total++;
      if (axis.m_tvalid !== 1'b0 || axis.s_tready !== 2'b00 || ep_sel !== 2'b00 || busy !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got v=%b rdy=%b sel=%b busy=%b err=%b want 0 00 00 0 0",
                  axis.m_tvalid, axis.s_tready, ep_sel, busy, err);
      end
      rst = 1'b0;
      idle_sources();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain_2: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_stall_hold();
      ep_ready = 2'b10;
      token(4'd2);
      axis.m_tready = 1'b0;
      drive_ep1(8'hC0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== 8'hC0 || axis.s_tready !== 2'b00) begin
            bad++;
            $display("FAIL stall_hold: got v=%b d=%0h rdy=%b want 1 c0 00", axis.m_tvalid, axis.m_tdata, axis.s_tready);
         end
         next_cycle();
      end
      axis.m_tready = 1'b1;
      drive_ep1(8'hC0, 1'b0);
      next_cycle();
      idle_sources();
      for (int i = 0; i < 255; i++) next_cycle();
      drive_ep1(8'hC1, 1'b1);
      next_cycle();
      idle_sources();
      #1;
      total++;
      if (err !== 1'b0 || busy !== 1'b1 || axis.m_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL wd_reload: got err=%b busy=%b v=%b want 0 1 0", err, busy, axis.m_tvalid);
      end
      ack = 1'b1;
      #1;
      total++;
      if (ep_ack !== 2'b10) begin
         bad++;
         $display("FAIL ack_after_stall: got %b want 10", ep_ack);
      end
      next_cycle();
      ack = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || stat_ack !== 16'(STATS) || sb.size() != 0) begin
         bad++;
         $display("FAIL stall_end: got busy=%b stat=%0d pending=%0d want 0 %0d 0", busy, stat_ack, sb.size(), STATS);
      end
   endtask

   initial begin
      test_reset();
      test_send_ack();
      test_nak();
      test_watchdog_abort();
      test_ack_tout();
      test_reset_mid();
      test_stall_hold();
      next_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
